serial_mag_comp: RTL and testbench

//  Parametrised, digit-serial magnitude comparator. Successor to the 2-bit combinational comparator.

---
 rtl/serial_mag_comp.sv | 120 ++++++++++++
 tb/tb_serial_mag_comp.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// Digit-serial magnitude comparator: scans two W-bit operands MSB digit first,
// DW bits per cycle, with start/busy/done handshake and optional early exit.
//
// state | meaning
// IDLE  | waiting for start; eq/lt/gt hold the last result
// SCAN  | comparing one digit per cycle, busy = 1
module serial_mag_comp #(
  parameter int W          = 8,
  parameter int DW         = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  localparam int NDIG = W / DW;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [W-1:0] MSB_MASK = {1'b1, {(W-1){1'b0}}};

  if (W < 2 || DW < 1 || (W % DW) != 0) begin : g_param_check
    $error("serial_mag_comp: W must be >= 2 and a multiple of DW");
  end

  typedef enum logic {IDLE, SCAN} state_t;
  typedef enum logic [1:0] {D_EQ, D_GT, D_LT} dec_t;

  state_t          state, state_nx;
  dec_t            dec, dec_nx, dec_now;
  logic [W-1:0]    op_a, op_b, op_a_nx, op_b_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            done_nx, eq_nx, lt_nx, gt_nx;
  logic [DW-1:0]   dig_a, dig_b;

  // Operands are shifted left each cycle, so the current digit is always on top.
  assign dig_a = op_a[W-1 -: DW];
  assign dig_b = op_b[W-1 -: DW];
  assign busy  = (state == SCAN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dec   <= D_EQ;
      op_a  <= '0;
      op_b  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= state_nx;
      dec   <= dec_nx;
      op_a  <= op_a_nx;
      op_b  <= op_b_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
      eq    <= eq_nx;
      lt    <= lt_nx;
      gt    <= gt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dec_nx   = dec;
    op_a_nx  = op_a;
    op_b_nx  = op_b;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    eq_nx    = eq;
    lt_nx    = lt;
    gt_nx    = gt;

    // A decided result is sticky; only an undecided scan looks at this digit.
    dec_now = dec;
    if (dec == D_EQ && dig_a != dig_b) begin
      dec_now = (dig_a > dig_b) ? D_GT : D_LT;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          // Flipping the sign bit maps two's complement onto offset binary.
          op_a_nx  = signed_mode ? (a ^ MSB_MASK) : a;
          op_b_nx  = signed_mode ? (b ^ MSB_MASK) : b;
          cnt_nx   = CW'(NDIG - 1);
          dec_nx   = D_EQ;
          eq_nx    = 1'b0;
          lt_nx    = 1'b0;
          gt_nx    = 1'b0;
        end
      end
      SCAN: begin
        op_a_nx = op_a << DW;
        op_b_nx = op_b << DW;
        cnt_nx  = cnt - CW'(1);
        dec_nx  = dec_now;
        if (cnt == '0 || (EARLY_EXIT != 0 && dec_now != D_EQ)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          eq_nx    = (dec_now == D_EQ);
          gt_nx    = (dec_now == D_GT);
          lt_nx    = (dec_now == D_LT);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp: early-exit, constant-time and DW == W builds
// side by side, with hand-computed latencies and results.
module tb_serial_mag_comp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       signed_mode = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic busy0, done0, eq0, lt0, gt0;
  logic busy1, done1, eq1, lt1, gt1;
  logic busy2, done2, eq2, lt2, gt2;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic busy_m, done_m;
  logic [2:0] res_m;

  always #5 clk = ~clk;

  serial_mag_comp #(.W(8), .DW(2), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy0), .done(done0), .eq(eq0), .lt(lt0), .gt(gt0));

  serial_mag_comp #(.W(8), .DW(2), .EARLY_EXIT(0)) u_const (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy1), .done(done1), .eq(eq1), .lt(lt1), .gt(gt1));

  serial_mag_comp #(.W(4), .DW(4), .EARLY_EXIT(1)) u_narrow (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a[3:0]), .b(b[3:0]), .signed_mode(signed_mode),
    .busy(busy2), .done(done2), .eq(eq2), .lt(lt2), .gt(gt2));

  // Result vectors are packed as {eq, lt, gt}.
  always_comb begin
    busy_m = busy0;
    done_m = done0;
    res_m  = {eq0, lt0, gt0};
    case (sel)
      1: begin busy_m = busy1; done_m = done1; res_m = {eq1, lt1, gt1}; end
      2: begin busy_m = busy2; done_m = done2; res_m = {eq2, lt2, gt2}; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Drive start for one edge; returns just after the accepting edge.
  task automatic launch(input int s, input logic [7:0] av, input logic [7:0] bv, input logic sm);
    sel = s;
    a = av;
    b = bv;
    signed_mode = sm;
    set_start(s, 1'b1);
    tick();
    set_start(s, 1'b0);
  endtask

  // Counts edges until done, plus how many sampled cycles showed busy.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles = 0;
    busy_cnt = 0;
    while (!done_m && cycles < 20) begin
      if (busy_m) busy_cnt++;
      tick();
      cycles++;
    end
  endtask

  task automatic run(input string tag, input int s, input logic [7:0] av, input logic [7:0] bv,
                     input logic sm, input int k_exp, input logic [2:0] res_exp);
    int k, bc;
    launch(s, av, bv, sm);
    check({tag, "_busy_start"}, 32'(busy_m), 32'd1);
    check({tag, "_res_clear"}, 32'(res_m), 32'd0);
    wait_done(k, bc);
    check({tag, "_latency"}, k, k_exp);
    check({tag, "_busy_cycles"}, bc, k_exp);
    check({tag, "_busy_at_done"}, 32'(busy_m), 32'd0);
    check({tag, "_result"}, 32'(res_m), 32'(res_exp));
  endtask

  initial begin
    int k, bc, pulses;

    tick();
    tick();
    check("reset_early", {28'd0, busy0, done0, eq0, lt0, gt0}, 32'd0);
    check("reset_const", {28'd0, busy1, done1, eq1, lt1, gt1}, 32'd0);
    check("reset_narrow", {28'd0, busy2, done2, eq2, lt2, gt2}, 32'd0);
    rst_n = 1'b1;
    tick();

    // All digits equal: full scan, eq.
    run("eq_5a", 0, 8'h5A, 8'h5A, 1'b0, 4, 3'b100);
    tick();
    check("done_one_cycle", 32'(done_m), 32'd0);
    check("eq_hold", 32'(res_m), 32'b100);

    // MSB digit differs: early exit after one digit.
    run("u_80_7f", 0, 8'h80, 8'h7F, 1'b0, 1, 3'b001);
    run("s_80_7f", 0, 8'h80, 8'h7F, 1'b1, 1, 3'b010);

    // Constant-time build scans all four digits regardless.
    run("ct_80_7f", 1, 8'h80, 8'h7F, 1'b0, 4, 3'b001);
    run("ct_s_01_ff", 1, 8'h01, 8'hFF, 1'b1, 4, 3'b001);

    // Last digit decides; a start mid-scan with new inputs must be ignored.
    launch(0, 8'h13, 8'h12, 1'b0);
    tick();
    a = 8'h00;
    b = 8'hFF;
    signed_mode = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("busy_ignore_start", 32'(busy_m), 32'd1);
    wait_done(k, bc);
    check("ignore_latency", k + 2, 4);
    check("ignore_result", 32'(res_m), 32'b001);

    // Back-to-back: start accepted in the done cycle.
    run("b2b_s_01_ff", 0, 8'h01, 8'hFF, 1'b1, 1, 3'b001);

    // Reset mid-scan aborts with no done afterwards.
    launch(0, 8'h00, 8'h03, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check("midscan_reset", {28'd0, busy0, done0, eq0, lt0, gt0}, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done0 || busy0) pulses++;
    end
    check("no_done_after_reset", pulses, 0);

    // Single-digit build: DW == W, signed -1 < 1.
    run("n_s_f_1", 2, 8'h0F, 8'h01, 1'b1, 1, 3'b010);
    run("n_u_f_1", 2, 8'h0F, 8'h01, 1'b0, 1, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
